pixel_stream_framer: RTL

Parametrised successor to the single-channel pixel pass-through used by the image text benches. It accepts a multi-channel pixel stream through a ready/valid handshake and buffers it in a small FIFO. Each output pixel is tagged with its x/y position and with start-of-frame, end-of-line and end-of-frame markers, derived from the configured image geometry. It sits between the image source (text reader bench or camera front-end) and downstream line-based filters.

---
 rtl/pixel_stream_framer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_stream_framer.sv
// Multi-channel pixel stream FIFO that tags each output pixel with x/y position and SOF/EOL/EOF markers.
// Optional per-frame checksum output when PIXEL_FRAMER_CHECKSUM_EN is defined.
module pixel_stream_framer #(
  parameter int PX_SIZE      = 8,
  parameter int NB_CHANNELS  = 1,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               frame_abort,
  input  logic [PX_SIZE*NB_CHANNELS-1:0]     input_data,
  input  logic                               input_data_valid,
  output logic                               input_data_ready,
  output logic [PX_SIZE*NB_CHANNELS-1:0]     output_data,
  output logic                               output_data_valid,
  input  logic                               output_data_ready,
  output logic [$clog2(IMAGE_WIDTH)-1:0]     output_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]    output_y,
  output logic                               output_sof,
  output logic                               output_eol,
  output logic                               output_eof,
  output logic                               frame_done,
  output logic [15:0]                        frame_count
`ifdef PIXEL_FRAMER_CHECKSUM_EN
  ,output logic [15:0]                       frame_checksum
`endif
);

  localparam int DW = PX_SIZE * NB_CHANNELS;
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XW-1:0] X_LAST   = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

  logic [DW-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_s;
  logic          ready_r, valid_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  state_t        state_r, state_s;
  logic          push_s, pop_s, sof_s, eol_s, eof_s, done_evt_s;
  logic          frame_done_r;
  logic [15:0]   frame_count_r;

  // Ready and valid are registered flags derived from next occupancy, so neither path is combinational.
  assign push_s = input_data_valid && ready_r;
  assign pop_s  = valid_r && output_data_ready;
  assign sof_s  = (x_r == {XW{1'b0}}) && (y_r == {YW{1'b0}});
  assign eol_s  = (x_r == X_LAST);
  assign eof_s  = eol_s && (y_r == Y_LAST);

  assign input_data_ready  = ready_r;
  assign output_data_valid = valid_r;
  assign output_data       = mem_r[rd_ptr_r];
  assign output_x          = x_r;
  assign output_y          = y_r;
  assign output_sof        = valid_r && sof_s;
  assign output_eol        = valid_r && eol_s;
  assign output_eof        = valid_r && eof_s;
  assign frame_done        = frame_done_r;
  assign frame_count       = frame_count_r;

  // Next occupancy and frame state machine transitions.
  always_comb begin
    count_s    = count_r;
    state_s    = state_r;
    done_evt_s = 1'b0;
    if (push_s && !pop_s) begin
      count_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_s = count_r - CW'(1);
    end else begin
      count_s = count_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (pop_s && sof_s) begin
          state_s = ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (pop_s && eof_s) begin
          state_s    = ST_IDLE;
          done_evt_s = 1'b1;
        end else begin
          state_s = ST_STREAM;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage write port; contents need no reset because occupancy guards visibility.
  always_ff @(posedge clk) begin
    if (resetn && !frame_abort && push_s) begin
      mem_r[wr_ptr_r] <= input_data;
    end
  end

  // Pointers, occupancy, position counters, FSM state and frame statistics.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      ready_r       <= 1'b0;
      valid_r       <= 1'b0;
      x_r           <= {XW{1'b0}};
      y_r           <= {YW{1'b0}};
      state_r       <= ST_IDLE;
      frame_done_r  <= 1'b0;
      frame_count_r <= 16'd0;
    end else if (frame_abort) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      ready_r      <= 1'b1;
      valid_r      <= 1'b0;
      x_r          <= {XW{1'b0}};
      y_r          <= {YW{1'b0}};
      state_r      <= ST_IDLE;
      frame_done_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        if (eol_s) begin
          x_r <= {XW{1'b0}};
          y_r <= (y_r == Y_LAST) ? {YW{1'b0}} : y_r + YW'(1);
        end else begin
          x_r <= x_r + XW'(1);
        end
      end
      count_r      <= count_s;
      ready_r      <= (count_s != FULL_CNT);
      valid_r      <= (count_s != {CW{1'b0}});
      state_r      <= state_s;
      frame_done_r <= done_evt_s;
      if (done_evt_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
    end
  end

`ifdef PIXEL_FRAMER_CHECKSUM_EN
  logic [15:0] run_sum_r;
  logic [15:0] frame_checksum_r;

  function automatic logic [15:0] channel_sum(input logic [DW-1:0] px);
    logic [15:0] acc;
    acc = 16'd0;
    for (int c = 0; c < NB_CHANNELS; c++) begin
      acc = acc + 16'(px[c*PX_SIZE +: PX_SIZE]);
    end
    return acc;
  endfunction

  assign frame_checksum = frame_checksum_r;

  // Running modular sum of popped channel values, latched at the end-of-frame pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_sum_r        <= 16'd0;
      frame_checksum_r <= 16'd0;
    end else if (frame_abort) begin
      run_sum_r <= 16'd0;
    end else if (done_evt_s) begin
      frame_checksum_r <= run_sum_r + channel_sum(output_data);
      run_sum_r        <= 16'd0;
    end else if (pop_s) begin
      run_sum_r <= run_sum_r + channel_sum(output_data);
    end
  end
`endif

endmodule
